// File: rtl/mem_stage_lsu.sv
// ME-stage load/store unit: one outstanding data-bus transaction per load/store, with busy stall to the hazard unit.
// Bus request issues combinationally from IDLE; result is valid in the ack cycle and held while the pipe is stalled.
module mem_stage_lsu #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReq_valid,
  input  logic              iWe,
  input  logic [2:0]        iFunct3,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [31:0]       iWdata,
  input  logic              iStall_pipe,
  input  logic              iFlush,
  output logic              oStall_ME,
  output logic              oBus_req,
  output logic              oBus_we,
  output logic [ADDR_W-1:0] oBus_addr,
  output logic [3:0]        oBus_be,
  output logic [31:0]       oBus_wdata,
  input  logic              iBus_gnt,
  input  logic              iBus_ack,
  input  logic [31:0]       iBus_rdata,
  output logic [31:0]       oRdata,
  output logic              oRdata_valid,
  output logic              oMisalign,
  output logic              oBusErr
);

  typedef enum logic [2:0] {IDLE, REQ, RESP, HOLD, DRAIN} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        alo_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;

  logic              misalign, issue, timeout, ld_cap;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [31:0]       ext_rd;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] alo);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{alo, 3'b000} +: 8];
    h = alo[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   extract = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   extract = {{16{h[15] & ~f3[2]}}, h};
      default: extract = w;
    endcase
  endfunction

  assign misalign = ((iFunct3[1:0] == 2'b01) && iAddr[0]) ||
                    ((iFunct3[1:0] == 2'b10) && (iAddr[1:0] != 2'b00));
  assign issue    = (state_q == IDLE) && iReq_valid && !misalign && !iFlush && !iRst;
  assign ext_rd   = extract(iBus_rdata, f3_q, alo_q);
  assign timeout  = ((state_q == RESP) || (state_q == DRAIN)) && !iBus_ack &&
                    (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = iWdata;
    case (iFunct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << iAddr[1:0];
        wdata_c = {4{iWdata[7:0]}};
      end
      2'b01: begin
        be_c    = iAddr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{iWdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ld_cap       = 1'b0;
    oBus_req     = 1'b0;
    oStall_ME    = 1'b0;
    oRdata       = '0;
    oRdata_valid = 1'b0;
    oBusErr      = timeout;
    oMisalign    = (state_q == IDLE) && iReq_valid && misalign && !iFlush && !iRst;
    case (state_q)
      IDLE: begin
        if (issue) begin
          oBus_req  = 1'b1;
          oStall_ME = 1'b1;
          cnt_d     = '0;
          state_d   = iBus_gnt ? RESP : REQ;
        end
      end
      REQ: begin
        // A flush withdraws the request before the fabric can grant it.
        oBus_req  = !iFlush;
        oStall_ME = iReq_valid;
        if (iFlush) begin
          state_d = IDLE;
        end else if (iBus_gnt) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        oStall_ME = iReq_valid && !iBus_ack && !timeout;
        cnt_d     = cnt_q + 8'd1;
        if (iBus_ack) begin
          if (iFlush) begin
            state_d = IDLE;
          end else begin
            oRdata_valid = !we_q;
            oRdata       = we_q ? '0 : ext_rd;
            ld_cap       = !we_q;
            state_d      = iStall_pipe ? HOLD : IDLE;
          end
        end else if (timeout) begin
          state_d = IDLE;
        end else if (iFlush) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        oRdata_valid = !we_q;
        oRdata       = we_q ? '0 : rdata_q;
        if (iFlush || !iStall_pipe) state_d = IDLE;
      end
      DRAIN: begin
        oStall_ME = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        if (iBus_ack || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!oBus_req) begin
      oBus_we    = 1'b0;
      oBus_addr  = '0;
      oBus_be    = '0;
      oBus_wdata = '0;
    end else if (state_q == IDLE) begin
      oBus_we    = iWe;
      oBus_addr  = {iAddr[ADDR_W-1:2], 2'b00};
      oBus_be    = be_c;
      oBus_wdata = wdata_c;
    end else begin
      oBus_we    = we_q;
      oBus_addr  = addr_q;
      oBus_be    = be_q;
      oBus_wdata = wdata_q;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      alo_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (issue) begin
        we_q    <= iWe;
        f3_q    <= iFunct3;
        alo_q   <= iAddr[1:0];
        addr_q  <= {iAddr[ADDR_W-1:2], 2'b00};
        be_q    <= be_c;
        wdata_q <= wdata_c;
      end
      if (ld_cap) rdata_q <= ext_rd;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a short bus timeout so the abort path is reachable.
module tb_mem_stage_lsu;
  logic        iClk = 1'b0;
  logic        iRst, iReq_valid, iWe, iStall_pipe, iFlush;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr, iWdata, iBus_rdata;
  logic        iBus_gnt, iBus_ack;
  logic        oStall_ME, oBus_req, oBus_we, oRdata_valid, oMisalign, oBusErr;
  logic [31:0] oBus_addr, oBus_wdata, oRdata;
  logic [3:0]  oBus_be;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 iClk = ~iClk;

  mem_stage_lsu #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .iClk(iClk), .iRst(iRst), .iReq_valid(iReq_valid), .iWe(iWe), .iFunct3(iFunct3),
    .iAddr(iAddr), .iWdata(iWdata), .iStall_pipe(iStall_pipe), .iFlush(iFlush),
    .oStall_ME(oStall_ME), .oBus_req(oBus_req), .oBus_we(oBus_we), .oBus_addr(oBus_addr),
    .oBus_be(oBus_be), .oBus_wdata(oBus_wdata), .iBus_gnt(iBus_gnt), .iBus_ack(iBus_ack),
    .iBus_rdata(iBus_rdata), .oRdata(oRdata), .oRdata_valid(oRdata_valid),
    .oMisalign(oMisalign), .oBusErr(oBusErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic quiet();
    iReq_valid = 0; iWe = 0; iBus_gnt = 0; iBus_ack = 0; iFlush = 0; iStall_pipe = 0;
    iBus_rdata = 0;
  endtask

  // Load granted in its first cycle and acked in the next.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [3:0] exp_be,
                         input logic [31:0] exp_d);
    iReq_valid = 1; iWe = 0; iFunct3 = f3; iAddr = a; iBus_gnt = 1;
    settle();
    check({tag, ".req"},   oBus_req, 1);
    check({tag, ".be"},    oBus_be, exp_be);
    check({tag, ".addr"},  oBus_addr, a & 32'hFFFF_FFFC);
    check({tag, ".stall0"}, oStall_ME, 1);
    step();
    iBus_gnt = 0; iBus_ack = 1; iBus_rdata = rd; iFunct3 = 3'b010; iAddr = 32'hFFFF_FFFF;
    settle();
    check({tag, ".vld"},    oRdata_valid, 1);
    check({tag, ".data"},   oRdata, exp_d);
    check({tag, ".stall1"}, oStall_ME, 0);
    step();
    quiet();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    quiet();
    iRst = 1; iFunct3 = 0; iAddr = 0; iWdata = 0;
    step(); step();
    settle();
    check("rst.req",   oBus_req, 0);
    check("rst.stall", oStall_ME, 0);
    check("rst.vld",   oRdata_valid, 0);
    check("rst.data",  oRdata, 0);
    check("rst.err",   oBusErr, 0);
    check("rst.mis",   oMisalign, 0);
    iRst = 0;
    step();

    do_load("lw",  3'b010, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load("lb",  3'b000, 32'h103, 32'h80FF_FFFF, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h103, 32'h80FF_FFFF, 4'b1000, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h102, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h100, 32'h8001_1234, 4'b0011, 32'h0000_1234);
    do_load("lb1", 3'b000, 32'h101, 32'h0000_7F00, 4'b0010, 32'h0000_007F);

    // SH with grant delayed three cycles; input data changes while waiting
    iReq_valid = 1; iWe = 1; iFunct3 = 3'b001; iAddr = 32'h202; iWdata = 32'h1234_ABCD;
    for (int c = 0; c < 4; c++) begin
      iBus_gnt = (c == 3);
      if (c == 1) iWdata = 32'h0;
      settle();
      check($sformatf("sh.req%0d", c),   oBus_req, 1);
      check($sformatf("sh.stall%0d", c), oStall_ME, 1);
      if (c == 3) begin
        check("sh.be",    oBus_be, 4'b1100);
        check("sh.wdata", oBus_wdata, 32'hABCD_ABCD);
        check("sh.addr",  oBus_addr, 32'h200);
        check("sh.we",    oBus_we, 1);
      end
      step();
    end
    iBus_gnt = 0;
    settle();
    check("sh.wait.req",   oBus_req, 0);
    check("sh.wait.stall", oStall_ME, 1);
    step();
    iBus_ack = 1;
    settle();
    check("sh.ack.stall", oStall_ME, 0);
    check("sh.ack.vld",   oRdata_valid, 0);
    step();
    quiet();

    // SB lane replication
    iReq_valid = 1; iWe = 1; iFunct3 = 3'b000; iAddr = 32'h201; iWdata = 32'h0000_0055;
    iBus_gnt = 1;
    settle();
    check("sb.be",    oBus_be, 4'b0010);
    check("sb.wdata", oBus_wdata, 32'h5555_5555);
    step();
    iBus_gnt = 0; iBus_ack = 1;
    step();
    quiet();

    // misaligned accesses
    iReq_valid = 1; iFunct3 = 3'b010; iAddr = 32'h101;
    settle();
    check("misw.pulse", oMisalign, 1);
    check("misw.req",   oBus_req, 0);
    check("misw.stall", oStall_ME, 0);
    step();
    iFunct3 = 3'b001; iAddr = 32'h103;
    settle();
    check("mish.pulse", oMisalign, 1);
    check("mish.req",   oBus_req, 0);
    step();
    quiet();
    settle();
    check("mis.clear", oMisalign, 0);
    step();

    // flush in RESP, ack two cycles later
    iReq_valid = 1; iFunct3 = 3'b010; iAddr = 32'h100; iBus_gnt = 1;
    step();
    iBus_gnt = 0; iFlush = 1;
    settle();
    check("fl.resp.vld", oRdata_valid, 0);
    step();
    iFlush = 0; iReq_valid = 0;
    settle();
    check("fl.drain.stall", oStall_ME, 1);
    check("fl.drain.req",   oBus_req, 0);
    step();
    iBus_ack = 1; iBus_rdata = 32'hCAFE_F00D;
    settle();
    check("fl.ack.stall", oStall_ME, 1);
    check("fl.ack.vld",   oRdata_valid, 0);
    step();
    quiet();
    settle();
    check("fl.idle.stall", oStall_ME, 0);
    step();

    // no ack: abort after four waiting cycles
    iReq_valid = 1; iFunct3 = 3'b010; iAddr = 32'h300; iBus_gnt = 1;
    step();
    iBus_gnt = 0;
    for (int c = 1; c <= 4; c++) begin
      settle();
      check($sformatf("to.err%0d", c),   oBusErr, (c == 4));
      check($sformatf("to.stall%0d", c), oStall_ME, (c != 4));
      check($sformatf("to.vld%0d", c),   oRdata_valid, 0);
      step();
    end
    iBus_gnt = 1; iAddr = 32'h304;
    settle();
    check("to.after.err", oBusErr, 0);
    check("to.reissue",   oBus_req, 1);
    step();
    iBus_gnt = 0; iBus_ack = 1; iBus_rdata = 32'h0BAD_F00D;
    settle();
    check("to.next.data", oRdata, 32'h0BAD_F00D);
    step();
    quiet();

    // pipeline stall at ack holds the result without reissuing
    iReq_valid = 1; iFunct3 = 3'b010; iAddr = 32'h104; iBus_gnt = 1;
    step();
    iBus_gnt = 0; iBus_ack = 1; iBus_rdata = 32'h1122_3344; iStall_pipe = 1;
    settle();
    check("hold.ack.data", oRdata, 32'h1122_3344);
    step();
    iBus_ack = 0; iBus_rdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) iStall_pipe = 0;
      settle();
      check($sformatf("hold.vld%0d", c),  oRdata_valid, 1);
      check($sformatf("hold.data%0d", c), oRdata, 32'h1122_3344);
      check($sformatf("hold.req%0d", c),  oBus_req, 0);
      step();
    end
    quiet();
    settle();
    check("hold.exit.vld", oRdata_valid, 0);
    step();

    // ack together with flush discards the response and returns to IDLE
    iReq_valid = 1; iFunct3 = 3'b010; iAddr = 32'h108; iBus_gnt = 1;
    step();
    iBus_gnt = 0; iBus_ack = 1; iFlush = 1; iBus_rdata = 32'h5A5A_5A5A;
    settle();
    check("af.vld", oRdata_valid, 0);
    step();
    iBus_ack = 0; iFlush = 0; iBus_gnt = 1; iAddr = 32'h10C;
    settle();
    check("af.reissue", oBus_req, 1);
    step();
    iBus_gnt = 0; iBus_ack = 1;
    step();
    quiet();

    // reset while waiting for grant
    iReq_valid = 1; iFunct3 = 3'b010; iAddr = 32'h110;
    settle();
    check("rm.req", oBus_req, 1);
    step();
    iRst = 1;
    step();
    iRst = 0; iReq_valid = 0;
    settle();
    check("rm.after.req",   oBus_req, 0);
    check("rm.after.stall", oStall_ME, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
